// File: rtl/ceres_pkg.sv
// Shared types for the core's memory hierarchy: lower-level request/response
// structs and the state/owner encodings used by the lowX arbiter.
package ceres_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned BLK_SIZE = 128;
  localparam int unsigned STREAK_W = 4;

  typedef enum logic [1:0] {
    RW_BYTE,
    RW_HALF,
    RW_WORD,
    RW_DOUBLE
  } rw_size_e;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [XLEN-1:0]     addr;
    rw_size_e            rw_size;
    logic                rw;
    logic [BLK_SIZE-1:0] data;
    logic                uncached;
  } lowX_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] data;
  } lowX_res_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE
  } lowx_arb_state_e;

  typedef enum logic {
    OWN_IC,
    OWN_DC
  } lowx_owner_e;

endpackage

// File: rtl/lowx_arbiter_if.sv
// Bundle of the three lowX channels around the arbiter: icache, dcache and memory.
// The master side drives the cache requests and the memory response.
interface lowx_arbiter_if;
  import ceres_pkg::*;

  lowX_req_t ic_req;
  lowX_res_t ic_res;
  lowX_req_t dc_req;
  lowX_res_t dc_res;
  lowX_req_t mem_req;
  lowX_res_t mem_res;

  modport master (
    output ic_req, dc_req, mem_res,
    input  ic_res, dc_res, mem_req
  );

  modport slave (
    input  ic_req, dc_req, mem_res,
    output ic_res, dc_res, mem_req
  );

endinterface

// File: rtl/lowx_arb_sel.sv
// Winner selection for the lowX arbiter: dcache first, unless it has already
// won DC_STREAK_MAX times in a row while icache was waiting.
module lowx_arb_sel
  import ceres_pkg::*;
#(
  parameter int unsigned DC_STREAK_MAX = 4
) (
  input  logic                en_i,
  input  logic                ic_valid_i,
  input  logic                dc_valid_i,
  input  logic [STREAK_W-1:0] streak_i,
  output logic                ic_gnt_o,
  output logic                dc_gnt_o,
  output logic [STREAK_W-1:0] streak_o
);

  localparam logic [STREAK_W-1:0] StreakMax = STREAK_W'(DC_STREAK_MAX);

  logic dcPick;
  logic icPick;

  // The streak only counts dcache wins that actually kept icache waiting.
  always_comb begin
    dcPick   = dc_valid_i && (!ic_valid_i || (streak_i < StreakMax));
    icPick   = ic_valid_i && !dcPick;
    dc_gnt_o = en_i && dcPick;
    ic_gnt_o = en_i && icPick;
    streak_o = streak_i;
    if (dc_gnt_o) begin
      if (!ic_valid_i) begin
        streak_o = '0;
      end else if (streak_i < StreakMax) begin
        streak_o = streak_i + STREAK_W'(1);
      end
    end else if (ic_gnt_o) begin
      streak_o = '0;
    end
  end

endmodule

// File: rtl/lowx_arbiter.sv
// Shares one lower-level memory port between icache and dcache, one block
// transaction in flight at a time.
module lowx_arbiter #(
  parameter int unsigned XLEN          = ceres_pkg::XLEN,
  parameter int unsigned BLK_SIZE      = ceres_pkg::BLK_SIZE,
  parameter int unsigned DC_STREAK_MAX = 4,
  parameter type         lowX_req_t    = ceres_pkg::lowX_req_t,
  parameter type         lowX_res_t    = ceres_pkg::lowX_res_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  lowX_req_t ic_req_i,
  output lowX_res_t ic_res_o,
  input  lowX_req_t dc_req_i,
  output lowX_res_t dc_res_o,
  output lowX_req_t mem_req_o,
  input  lowX_res_t mem_res_i
);

  import ceres_pkg::*;

  lowx_arb_state_e     state_q, state_d;
  lowx_owner_e         owner_q;
  lowX_req_t           req_q;
  logic [BLK_SIZE-1:0] data_q;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic icGnt;
  logic dcGnt;
  logic selEn;
  logic latchData;

  // Grants are masked during reset so no requester sees ready while rst_ni is low.
  assign selEn     = (state_q == ARB_IDLE) && rst_ni;
  assign latchData = mem_res_i.valid &&
                     (((state_q == ARB_ISSUE) && mem_res_i.ready) || (state_q == ARB_WAIT));

  lowx_arb_sel #(
    .DC_STREAK_MAX(DC_STREAK_MAX)
  ) u_sel (
    .en_i      (selEn),
    .ic_valid_i(ic_req_i.valid),
    .dc_valid_i(dc_req_i.valid),
    .streak_i  (streak_q),
    .ic_gnt_o  (icGnt),
    .dc_gnt_o  (dcGnt),
    .streak_o  (streak_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (icGnt || dcGnt) begin
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (mem_res_i.ready) begin
          state_d = mem_res_i.valid ? ARB_DONE : ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_res_i.valid) begin
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Responses to the caches come only from registers, never straight from memory.
  always_comb begin
    mem_req_o       = req_q;
    mem_req_o.addr  = req_q.addr[XLEN-1:0];
    mem_req_o.valid = 1'b0;
    mem_req_o.ready = 1'b0;
    ic_res_o        = '0;
    dc_res_o        = '0;
    unique case (state_q)
      ARB_IDLE: begin
        ic_res_o.ready = icGnt;
        dc_res_o.ready = dcGnt;
      end
      ARB_ISSUE: begin
        mem_req_o.valid = 1'b1;
        mem_req_o.ready = 1'b1;
      end
      ARB_WAIT: begin
        mem_req_o.ready = 1'b1;
      end
      ARB_DONE: begin
        if (owner_q == OWN_DC) begin
          dc_res_o.valid = 1'b1;
          dc_res_o.data  = data_q;
        end else begin
          ic_res_o.valid = 1'b1;
          ic_res_o.data  = data_q;
        end
      end
      default: begin
        mem_req_o.valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q    <= '0;
      data_q   <= '0;
      owner_q  <= OWN_IC;
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
      if (dcGnt) begin
        req_q       <= dc_req_i;
        req_q.valid <= 1'b0;
        req_q.ready <= 1'b0;
        owner_q     <= OWN_DC;
      end else if (icGnt) begin
        req_q       <= ic_req_i;
        req_q.valid <= 1'b0;
        req_q.ready <= 1'b0;
        owner_q     <= OWN_IC;
      end
      if (latchData) begin
        data_q <= mem_res_i.data;
      end
    end
  end

endmodule

// File: tb/tb_lowx_arbiter.sv
// Self-checking bench for lowx_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level arbitration model.
module tb_lowx_arbiter;
  import ceres_pkg::*;

  localparam int STREAK_MAX = 4;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   nChecks = 0;
  int   nFail = 0;
  int   modelStreak = 0;

  always #5 clock = ~clock;

  lowx_arbiter_if bus();

  lowx_arbiter #(
    .DC_STREAK_MAX(STREAK_MAX)
  ) dut (
    .clk_i    (clock),
    .rst_ni   (rst_n),
    .ic_req_i (bus.ic_req),
    .ic_res_o (bus.ic_res),
    .dc_req_i (bus.dc_req),
    .dc_res_o (bus.dc_res),
    .mem_req_o(bus.mem_req),
    .mem_res_i(bus.mem_res)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Memory side driver: ready after rdyDelay cycles, valid gap cycles later
  // (gap 0 = same cycle). Returns just after the edge into DONE.
  task automatic serveMem(input int rdyDelay, input int gap, input logic [BLK_SIZE-1:0] d);
    bus.mem_res = '0;
    repeat (rdyDelay) tick();
    bus.mem_res.ready = 1'b1;
    if (gap == 0) begin
      bus.mem_res.valid = 1'b1;
      bus.mem_res.data  = d;
    end
    tick();
    bus.mem_res = '0;
    if (gap > 0) begin
      repeat (gap - 1) tick();
      bus.mem_res.valid = 1'b1;
      bus.mem_res.data  = d;
      tick();
      bus.mem_res = '0;
    end
  endtask

  task automatic test_reset();
    logic [BLK_SIZE-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    rst_n = 1'b0;
    bus.ic_req = '0;
    bus.dc_req = '0;
    bus.mem_res = '0;
    bus.ic_req.valid = 1'b1;
    bus.ic_req.addr  = 32'h80;
    bus.dc_req.valid = 1'b1;
    bus.dc_req.addr  = 32'h1000;
    repeat (2) begin
      @(negedge clock);
      nChecks++;
      if (bus.ic_res !== '0 || bus.dc_res !== '0 || bus.mem_req !== '0) begin
        nFail++;
        $display("[TB] FAIL reset_outputs: ic_res=%h dc_res=%h mem_req=%h, want all zero",
                 bus.ic_res, bus.dc_res, bus.mem_req);
      end
    end
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    @(negedge clock);
    nChecks++;
    if ({bus.ic_res.ready, bus.dc_res.ready} !== 2'b01) begin
      nFail++;
      $display("[TB] FAIL reset_first_grant: {ic,dc} ready=%b, want 01",
               {bus.ic_res.ready, bus.dc_res.ready});
    end
    modelStreak = 1;
    tick();
    bus.dc_req.valid = 1'b0;
    bus.ic_req.valid = 1'b0;
    @(negedge clock);
    nChecks++;
    if (bus.mem_req.valid !== 1'b1 || bus.mem_req.addr !== 32'h1000) begin
      nFail++;
      $display("[TB] FAIL reset_issue: valid=%b addr=%h, want 1 / 00001000",
               bus.mem_req.valid, bus.mem_req.addr);
    end
    serveMem(0, 0, d);
    @(negedge clock);
    nChecks++;
    if (bus.dc_res.valid !== 1'b1 || bus.dc_res.data !== d) begin
      nFail++;
      $display("[TB] FAIL reset_done: dc valid=%b data=%h, want 1 / %h",
               bus.dc_res.valid, bus.dc_res.data, d);
    end
    tick();
  endtask

  task automatic test_single_ic_read();
    logic [BLK_SIZE-1:0] d;
    d = BLK_SIZE'(64'hDEADBEEF_DEADBEEF);
    bus.ic_req = '0;
    bus.ic_req.valid = 1'b1;
    bus.ic_req.addr  = 32'h0000_0040;
    bus.ic_req.rw    = 1'b0;
    @(negedge clock);
    nChecks++;
    if ({bus.ic_res.ready, bus.dc_res.ready} !== 2'b10) begin
      nFail++;
      $display("[TB] FAIL ic_read_grant: {ic,dc} ready=%b, want 10",
               {bus.ic_res.ready, bus.dc_res.ready});
    end
    modelStreak = 0;
    tick();
    bus.ic_req.valid = 1'b0;
    @(negedge clock);
    nChecks++;
    if (bus.ic_res.ready !== 1'b0 || bus.mem_req.valid !== 1'b1 || bus.mem_req.addr !== 32'h40) begin
      nFail++;
      $display("[TB] FAIL ic_read_issue: ic ready=%b mem valid=%b addr=%h, want 0 / 1 / 00000040",
               bus.ic_res.ready, bus.mem_req.valid, bus.mem_req.addr);
    end
    serveMem(0, 3, d);
    @(negedge clock);
    nChecks++;
    if (bus.ic_res.valid !== 1'b1 || bus.ic_res.data !== d || bus.dc_res !== '0) begin
      nFail++;
      $display("[TB] FAIL ic_read_done: ic valid=%b data=%h dc_res=%h, want 1 / %h / 0",
               bus.ic_res.valid, bus.ic_res.data, bus.dc_res, d);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    logic [BLK_SIZE-1:0] d1, d2;
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    bus.ic_req = '0;
    bus.dc_req = '0;
    bus.ic_req.valid    = 1'b1;
    bus.ic_req.addr     = 32'h100;
    bus.dc_req.valid    = 1'b1;
    bus.dc_req.addr     = 32'h2000_0000;
    bus.dc_req.uncached = 1'b1;
    @(negedge clock);
    nChecks++;
    if ({bus.ic_res.ready, bus.dc_res.ready} !== 2'b01) begin
      nFail++;
      $display("[TB] FAIL simul_first: {ic,dc} ready=%b, want 01",
               {bus.ic_res.ready, bus.dc_res.ready});
    end
    modelStreak = 1;
    tick();
    bus.dc_req.valid = 1'b0;
    @(negedge clock);
    nChecks++;
    if (bus.mem_req.addr !== 32'h2000_0000 || bus.mem_req.uncached !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL simul_dc_issue: addr=%h uncached=%b, want 20000000 / 1",
               bus.mem_req.addr, bus.mem_req.uncached);
    end
    serveMem(1, 1, d1);
    @(negedge clock);
    nChecks++;
    if (bus.dc_res.valid !== 1'b1 || bus.dc_res.data !== d1 || bus.ic_res.ready !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL simul_dc_done: dc valid=%b data=%h ic ready=%b, want 1 / %h / 0",
               bus.dc_res.valid, bus.dc_res.data, bus.ic_res.ready, d1);
    end
    tick();
    @(negedge clock);
    nChecks++;
    if ({bus.ic_res.ready, bus.dc_res.ready} !== 2'b10) begin
      nFail++;
      $display("[TB] FAIL simul_second: {ic,dc} ready=%b, want 10",
               {bus.ic_res.ready, bus.dc_res.ready});
    end
    modelStreak = 0;
    tick();
    bus.ic_req.valid = 1'b0;
    @(negedge clock);
    nChecks++;
    if (bus.mem_req.addr !== 32'h100 || bus.mem_req.uncached !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL simul_ic_issue: addr=%h uncached=%b, want 00000100 / 0",
               bus.mem_req.addr, bus.mem_req.uncached);
    end
    serveMem(0, 0, d2);
    @(negedge clock);
    nChecks++;
    if (bus.ic_res.valid !== 1'b1 || bus.ic_res.data !== d2) begin
      nFail++;
      $display("[TB] FAIL simul_ic_done: ic valid=%b data=%h, want 1 / %h",
               bus.ic_res.valid, bus.ic_res.data, d2);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic [XLEN-1:0]     dcAddr;
    logic [XLEN-1:0]     expAddr;
    logic [BLK_SIZE-1:0] d;
    logic                expIc;
    dcAddr = '0;
    bus.ic_req = '0;
    bus.dc_req = '0;
    bus.ic_req.valid = 1'b1;
    bus.ic_req.addr  = 32'h300;
    bus.dc_req.valid = 1'b1;
    for (int k = 0; k < STREAK_MAX + 2; k++) begin
      bus.dc_req.addr = dcAddr;
      expIc = (k == STREAK_MAX);
      @(negedge clock);
      nChecks++;
      if ({bus.ic_res.ready, bus.dc_res.ready} !== {expIc, !expIc}) begin
        nFail++;
        $display("[TB] FAIL starve_grant%0d: {ic,dc} ready=%b, want %b",
                 k, {bus.ic_res.ready, bus.dc_res.ready}, {expIc, !expIc});
      end
      modelStreak = expIc ? 0 : modelStreak + 1;
      tick();
      expAddr = expIc ? 32'h300 : dcAddr;
      if (!expIc) dcAddr = dcAddr + 32'h40;
      if (k == STREAK_MAX + 1) begin
        bus.ic_req.valid = 1'b0;
        bus.dc_req.valid = 1'b0;
      end
      @(negedge clock);
      nChecks++;
      if (bus.mem_req.valid !== 1'b1 || bus.mem_req.addr !== expAddr) begin
        nFail++;
        $display("[TB] FAIL starve_issue%0d: valid=%b addr=%h, want 1 / %h",
                 k, bus.mem_req.valid, bus.mem_req.addr, expAddr);
      end
      d = {$urandom, $urandom, $urandom, $urandom};
      serveMem(0, 0, d);
      tick();
    end
  endtask

  task automatic test_same_cycle();
    logic [BLK_SIZE-1:0] wdata, resp;
    wdata = BLK_SIZE'(64'hCAFEBABE_00000001);
    resp  = {$urandom, $urandom, $urandom, $urandom};
    bus.ic_req = '0;
    bus.dc_req = '0;
    bus.dc_req.valid = 1'b1;
    bus.dc_req.addr  = 32'h240;
    bus.dc_req.rw    = 1'b1;
    bus.dc_req.data  = wdata;
    @(negedge clock);
    nChecks++;
    if ({bus.ic_res.ready, bus.dc_res.ready} !== 2'b01) begin
      nFail++;
      $display("[TB] FAIL samecyc_grant: {ic,dc} ready=%b, want 01",
               {bus.ic_res.ready, bus.dc_res.ready});
    end
    modelStreak = 0;
    tick();
    bus.dc_req.valid  = 1'b0;
    bus.mem_res.ready = 1'b1;
    bus.mem_res.valid = 1'b1;
    bus.mem_res.data  = resp;
    @(negedge clock);
    nChecks++;
    if (bus.mem_req.valid !== 1'b1 || bus.mem_req.rw !== 1'b1 || bus.mem_req.data !== wdata) begin
      nFail++;
      $display("[TB] FAIL samecyc_issue: valid=%b rw=%b data=%h, want 1 / 1 / %h",
               bus.mem_req.valid, bus.mem_req.rw, bus.mem_req.data, wdata);
    end
    tick();
    bus.mem_res = '0;
    @(negedge clock);
    nChecks++;
    if (bus.dc_res.valid !== 1'b1 || bus.dc_res.data !== resp) begin
      nFail++;
      $display("[TB] FAIL samecyc_done: dc valid=%b data=%h, want 1 / %h",
               bus.dc_res.valid, bus.dc_res.data, resp);
    end
    tick();
    @(negedge clock);
    nChecks++;
    if (bus.dc_res.valid !== 1'b0 || bus.mem_req.valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL samecyc_after: dc valid=%b mem valid=%b, want 0 / 0",
               bus.dc_res.valid, bus.mem_req.valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [BLK_SIZE-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    tick();
    bus.dc_req = '0;
    bus.dc_req.valid = 1'b1;
    bus.dc_req.addr  = 32'h500;
    @(negedge clock);
    nChecks++;
    if (bus.dc_res.ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL rstmid_grant: dc ready=%b, want 1", bus.dc_res.ready);
    end
    tick();
    bus.dc_req.valid  = 1'b0;
    bus.mem_res.ready = 1'b1;
    tick();
    bus.mem_res = '0;
    @(negedge clock);
    nChecks++;
    if (bus.mem_req.valid !== 1'b0 || bus.mem_req.ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL rstmid_wait: mem valid=%b ready=%b, want 0 / 1",
               bus.mem_req.valid, bus.mem_req.ready);
    end
    #1;
    rst_n = 1'b0;
    modelStreak = 0;
    #1;
    nChecks++;
    if (bus.ic_res !== '0 || bus.dc_res !== '0 || bus.mem_req !== '0) begin
      nFail++;
      $display("[TB] FAIL rstmid_async: ic_res=%h dc_res=%h mem_req=%h, want all zero",
               bus.ic_res, bus.dc_res, bus.mem_req);
    end
    @(posedge clock);
    tick();
    rst_n = 1'b1;
    bus.mem_res.valid = 1'b1;
    bus.mem_res.data  = d;
    @(negedge clock);
    nChecks++;
    if (bus.ic_res.valid !== 1'b0 || bus.dc_res.valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL rstmid_drop0: ic valid=%b dc valid=%b, want 0 / 0",
               bus.ic_res.valid, bus.dc_res.valid);
    end
    tick();
    bus.mem_res = '0;
    @(negedge clock);
    nChecks++;
    if (bus.ic_res.valid !== 1'b0 || bus.dc_res.valid !== 1'b0 || bus.mem_req.valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL rstmid_drop1: ic valid=%b dc valid=%b mem valid=%b, want 0 / 0 / 0",
               bus.ic_res.valid, bus.dc_res.valid, bus.mem_req.valid);
    end
    tick();
    bus.ic_req = '0;
    bus.ic_req.valid = 1'b1;
    bus.ic_req.addr  = 32'h600;
    @(negedge clock);
    nChecks++;
    if (bus.ic_res.ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL rstmid_idle: ic ready=%b, want 1", bus.ic_res.ready);
    end
    tick();
    bus.ic_req.valid = 1'b0;
    serveMem(0, 0, d);
    @(negedge clock);
    nChecks++;
    if (bus.ic_res.valid !== 1'b1 || bus.ic_res.data !== d) begin
      nFail++;
      $display("[TB] FAIL rstmid_resume: ic valid=%b data=%h, want 1 / %h",
               bus.ic_res.valid, bus.ic_res.data, d);
    end
    tick();
  endtask

  task automatic test_random();
    logic                icPend, dcPend, expIc, expDc;
    lowX_req_t           icTxn, dcTxn, exp;
    logic [BLK_SIZE-1:0] resp;
    int                  rdy, gap;
    icPend = 1'b0;
    dcPend = 1'b0;
    icTxn  = '0;
    dcTxn  = '0;
    for (int t = 0; t < 40; t++) begin
      if (!icPend && ($urandom_range(0, 1) == 1)) begin
        icPend        = 1'b1;
        icTxn.addr    = XLEN'($urandom_range(0, 1023)) << 6;
        icTxn.rw_size = rw_size_e'($urandom_range(0, 3));
        icTxn.rw      = 1'b0;
        icTxn.data    = {$urandom, $urandom, $urandom, $urandom};
        icTxn.uncached = 1'(($urandom_range(0, 3) == 0));
      end
      if ((!dcPend && ($urandom_range(0, 1) == 1)) || (!icPend && !dcPend)) begin
        dcPend        = 1'b1;
        dcTxn.addr    = XLEN'($urandom_range(0, 1023)) << 6;
        dcTxn.rw_size = rw_size_e'($urandom_range(0, 3));
        dcTxn.rw      = 1'($urandom_range(0, 1));
        dcTxn.data    = {$urandom, $urandom, $urandom, $urandom};
        dcTxn.uncached = 1'($urandom_range(0, 1));
      end
      bus.ic_req = icTxn;
      bus.ic_req.valid = icPend;
      bus.dc_req = dcTxn;
      bus.dc_req.valid = dcPend;
      expDc = dcPend && (!icPend || (modelStreak < STREAK_MAX));
      expIc = icPend && !expDc;
      if (expDc) begin
        if (!icPend) modelStreak = 0;
        else if (modelStreak < STREAK_MAX) modelStreak++;
      end else begin
        modelStreak = 0;
      end
      @(negedge clock);
      nChecks++;
      if ({bus.ic_res.ready, bus.dc_res.ready} !== {expIc, expDc}) begin
        nFail++;
        $display("[TB] FAIL rand%0d_grant: {ic,dc} ready=%b, want %b",
                 t, {bus.ic_res.ready, bus.dc_res.ready}, {expIc, expDc});
      end
      tick();
      if (expDc) begin
        exp = dcTxn;
        dcPend = 1'b0;
        bus.dc_req.valid = 1'b0;
      end else begin
        exp = icTxn;
        icPend = 1'b0;
        bus.ic_req.valid = 1'b0;
      end
      rdy  = $urandom_range(0, 2);
      gap  = $urandom_range(0, 2);
      resp = {$urandom, $urandom, $urandom, $urandom};
      bus.mem_res = '0;
      for (int k = 0; k <= rdy; k++) begin
        if (k == rdy) begin
          bus.mem_res.ready = 1'b1;
          if (gap == 0) begin
            bus.mem_res.valid = 1'b1;
            bus.mem_res.data  = resp;
          end
        end
        @(negedge clock);
        nChecks++;
        if ({bus.mem_req.valid, bus.mem_req.addr, bus.mem_req.rw_size, bus.mem_req.rw,
             bus.mem_req.data, bus.mem_req.uncached} !==
            {1'b1, exp.addr, exp.rw_size, exp.rw, exp.data, exp.uncached}) begin
          nFail++;
          $display("[TB] FAIL rand%0d_issue: addr=%h rw=%b data=%h unc=%b valid=%b, want %h / %b / %h / %b / 1",
                   t, bus.mem_req.addr, bus.mem_req.rw, bus.mem_req.data, bus.mem_req.uncached,
                   bus.mem_req.valid, exp.addr, exp.rw, exp.data, exp.uncached);
        end
        tick();
      end
      bus.mem_res = '0;
      if (gap > 0) begin
        for (int k = 0; k < gap; k++) begin
          if (k == gap - 1) begin
            bus.mem_res.valid = 1'b1;
            bus.mem_res.data  = resp;
          end
          @(negedge clock);
          nChecks++;
          if ({bus.mem_req.valid, bus.mem_req.ready, bus.ic_res.valid, bus.dc_res.valid} !== 4'b0100) begin
            nFail++;
            $display("[TB] FAIL rand%0d_wait: {memvalid,memready,icvalid,dcvalid}=%b, want 0100",
                     t, {bus.mem_req.valid, bus.mem_req.ready, bus.ic_res.valid, bus.dc_res.valid});
          end
          tick();
        end
        bus.mem_res = '0;
      end
      @(negedge clock);
      nChecks++;
      if ({bus.ic_res.valid, bus.dc_res.valid, bus.ic_res.ready, bus.dc_res.ready} !== {expIc, expDc, 2'b00} ||
          (expDc ? bus.dc_res.data : bus.ic_res.data) !== resp) begin
        nFail++;
        $display("[TB] FAIL rand%0d_done: {icv,dcv,icr,dcr}=%b data=%h, want %b / %h",
                 t, {bus.ic_res.valid, bus.dc_res.valid, bus.ic_res.ready, bus.dc_res.ready},
                 expDc ? bus.dc_res.data : bus.ic_res.data, {expIc, expDc, 2'b00}, resp);
      end
      tick();
    end
    bus.ic_req = '0;
    bus.dc_req = '0;
  endtask

  initial begin
    test_reset();
    test_single_ic_read();
    test_simultaneous();
    test_starvation();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
